// File: rtl/mem_arb_pkg.sv
// Shared types for the main-memory arbiter.
//   state_t : transaction FSM state (IDLE -> REQ -> WAIT -> IDLE)
//   owner_t : which requester owns the transaction in flight
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_LS   = 2'd2
   } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of every handshake/bus signal around the memory arbiter.
//   if_*  : instruction-fetch requester (read only)
//   ls_*  : load/store requester
//   mem_* : single main-memory port
//   busy  : arbiter has a transaction in flight
// Modports:
//   master : the arbiter itself (drives grants, responses and the memory request)
//   slave  : the surrounding environment (requesters and memory)
interface mem_arbiter_if #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
);
   logic                  if_req;
   logic [ADDR_W-1:0]     if_addr;
   logic                  if_gnt;
   logic                  if_rvalid;
   logic [XLEN-1:0]       if_rdata;

   logic                  ls_req;
   logic                  ls_we;
   logic [ADDR_W-1:0]     ls_addr;
   logic [XLEN-1:0]       ls_wdata;
   logic [XLEN/8-1:0]     ls_wstrb;
   logic                  ls_gnt;
   logic                  ls_rvalid;
   logic [XLEN-1:0]       ls_rdata;

   logic                  mem_req;
   logic                  mem_we;
   logic [ADDR_W-1:0]     mem_addr;
   logic [XLEN-1:0]       mem_wdata;
   logic [XLEN/8-1:0]     mem_wstrb;
   logic                  mem_gnt;
   logic                  mem_rvalid;
   logic [XLEN-1:0]       mem_rdata;

   logic                  busy;

   modport master (
      input  if_req, if_addr,
      output if_gnt, if_rvalid, if_rdata,
      input  ls_req, ls_we, ls_addr, ls_wdata, ls_wstrb,
      output ls_gnt, ls_rvalid, ls_rdata,
      output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
      input  mem_gnt, mem_rvalid, mem_rdata,
      output busy
   );

   modport slave (
      output if_req, if_addr,
      input  if_gnt, if_rvalid, if_rdata,
      output ls_req, ls_we, ls_addr, ls_wdata, ls_wstrb,
      input  ls_gnt, ls_rvalid, ls_rdata,
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
      output mem_gnt, mem_rvalid, mem_rdata,
      input  busy
   );
endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select between instruction fetch and load/store.
//   i_if_req      : fetch is requesting
//   i_ls_req      : load/store is requesting
//   i_streak_full : load/store has won STREAK_MAX times in a row while fetch waited
//   o_pick_if     : fetch wins this cycle
//   o_pick_ls     : load/store wins this cycle
module mem_arb_pick (
   input  logic i_if_req,
   input  logic i_ls_req,
   input  logic i_streak_full,
   output logic o_pick_if,
   output logic o_pick_ls
);
   // LS has priority unless fetch has been waiting through a full streak.
   assign o_pick_ls = i_ls_req && !(i_if_req && i_streak_full);
   assign o_pick_if = i_if_req && !o_pick_ls;
endmodule

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between instruction fetch and load/store.
// One transaction in flight at a time; LS has priority, a streak counter keeps
// fetch from starving.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : mem_arbiter_if master view (requesters, memory port, busy)
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int ADDR_W     = 32,
   parameter int STREAK_MAX = 4
)(
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.master bus
);
   localparam int STRB_W = XLEN / 8;
   localparam int SW     = $clog2(STREAK_MAX + 1);

   state_t              r_state;
   owner_t              r_owner;
   logic [SW-1:0]       r_streak;

   logic                r_mem_req;
   logic                r_mem_we;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [XLEN-1:0]     r_mem_wdata;
   logic [STRB_W-1:0]   r_mem_wstrb;

   logic                r_if_rvalid;
   logic                r_ls_rvalid;
   logic [XLEN-1:0]     r_if_rdata;
   logic [XLEN-1:0]     r_ls_rdata;

   logic                w_idle;
   logic                w_streak_full;
   logic                w_pick_if;
   logic                w_pick_ls;

   assign w_idle        = (r_state == IDLE);
   assign w_streak_full = (r_streak == SW'(STREAK_MAX));

   mem_arb_pick u_pick (
      .i_if_req      (bus.if_req),
      .i_ls_req      (bus.ls_req),
      .i_streak_full (w_streak_full),
      .o_pick_if     (w_pick_if),
      .o_pick_ls     (w_pick_ls)
   );

   // Grants are same-cycle pulses; gated by rst so every output is 0 in reset.
   assign bus.if_gnt    = w_idle && w_pick_if && !rst;
   assign bus.ls_gnt    = w_idle && w_pick_ls && !rst;

   assign bus.mem_req   = r_mem_req;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.mem_wstrb = r_mem_wstrb;

   assign bus.if_rvalid = r_if_rvalid;
   assign bus.if_rdata  = r_if_rdata;
   assign bus.ls_rvalid = r_ls_rvalid;
   assign bus.ls_rdata  = r_ls_rdata;

   assign bus.busy      = !w_idle;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_owner     <= OWN_NONE;
         r_streak    <= '0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_wstrb <= '0;
         r_if_rvalid <= 1'b0;
         r_ls_rvalid <= 1'b0;
         r_if_rdata  <= '0;
         r_ls_rdata  <= '0;
      end else begin
         r_if_rvalid <= 1'b0;
         r_ls_rvalid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_pick_ls) begin
                  r_owner     <= OWN_LS;
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= bus.ls_we;
                  r_mem_addr  <= bus.ls_addr;
                  r_mem_wdata <= bus.ls_wdata;
                  r_mem_wstrb <= bus.ls_wstrb;
                  r_state     <= REQ;
                  // Count only grants that made a waiting fetch lose.
                  if (!bus.if_req)
                     r_streak <= '0;
                  else if (!w_streak_full)
                     r_streak <= r_streak + SW'(1);
               end else if (w_pick_if) begin
                  r_owner     <= OWN_IF;
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= 1'b0;
                  r_mem_addr  <= bus.if_addr;
                  r_mem_wdata <= '0;
                  r_mem_wstrb <= '1;
                  r_state     <= REQ;
                  r_streak    <= '0;
               end
            end
            REQ: begin
               if (bus.mem_gnt) begin
                  r_mem_req <= 1'b0;
                  r_state   <= WAIT;
               end
            end
            WAIT: begin
               if (bus.mem_rvalid) begin
                  if (r_owner == OWN_IF) begin
                     r_if_rvalid <= 1'b1;
                     r_if_rdata  <= bus.mem_rdata;
                  end
                  if (r_owner == OWN_LS) begin
                     r_ls_rvalid <= 1'b1;
                     r_ls_rdata  <= bus.mem_rdata;
                  end
                  r_owner <= OWN_NONE;
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state   <= IDLE;
               r_owner   <= OWN_NONE;
               r_mem_req <= 1'b0;
            end
         endcase
      end
   end
endmodule
